// File: rtl/reply_scheduler.sv
// reply_scheduler
//
// Answers every command-match event from the receive-side string matcher
// by streaming a fixed ASCII reply into the UART transmitter, one byte at
// a time, over a start/busy handshake. Match results are buffered in a
// 4-entry FIFO so that bursts of matches are not lost while a reply is
// still being sent.
//
// Parameters
//   ACK_TIMEOUT     cycles to wait for tx_busy_i to rise after a start
//                   before the byte is treated as sent (2..255)
//
// Ports
//   clk_i           system clock
//   rst_n_i         synchronous active-low reset
//   match_i         one-cycle match event from the matcher
//   match_result_i  ASCII result code, sampled when match_i=1
//   tx_busy_i       UART TX busy flag
//   tx_start_o      one-cycle request to send tx_data_o
//   tx_data_o       byte to send, stable from one start to the next
//   last_result_o   most recent match_result_i seen with match_i
//   drop_cnt_o      saturating count of matches lost to a full FIFO
//   sched_busy_o    high while the FIFO holds entries or a reply is active

module reply_scheduler #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       match_i,
  input  logic [7:0] match_result_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic [7:0] last_result_o,
  output logic [7:0] drop_cnt_o,
  output logic       sched_busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } state_e;

  localparam logic [7:0] TimerLast = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] txData_q, txData_d;

  logic [1:0] fifoMem_q [4];
  logic [1:0] wrPtr_q, wrPtr_d;
  logic [1:0] rdPtr_q, rdPtr_d;
  logic [2:0] count_q, count_d;

  logic [7:0] lastResult_q, lastResult_d;
  logic [7:0] dropCnt_q, dropCnt_d;

  logic [1:0] matchCode;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       push;
  logic       pop;
  logic       drop;
  logic [2:0] lastIdx;

  // Number of bytes in the reply for a given code, CR LF included.
  function automatic logic [2:0] replyLen(input logic [1:0] code);
    logic [2:0] len;
    case (code)
      2'd0:    len = 3'd5;
      2'd1:    len = 3'd7;
      2'd2:    len = 3'd6;
      default: len = 3'd7;
    endcase
    return len;
  endfunction

  // Reply ROM: "ERR\r\n", "START\r\n", "STOP\r\n", "HITSZ\r\n".
  function automatic logic [7:0] replyByte(input logic [1:0] code, input logic [2:0] idx);
    logic [7:0] b;
    case ({code, idx})
      5'b00_000: b = 8'h45;
      5'b00_001: b = 8'h52;
      5'b00_010: b = 8'h52;
      5'b00_011: b = 8'h0D;
      5'b00_100: b = 8'h0A;
      5'b01_000: b = 8'h53;
      5'b01_001: b = 8'h54;
      5'b01_010: b = 8'h41;
      5'b01_011: b = 8'h52;
      5'b01_100: b = 8'h54;
      5'b01_101: b = 8'h0D;
      5'b01_110: b = 8'h0A;
      5'b10_000: b = 8'h53;
      5'b10_001: b = 8'h54;
      5'b10_010: b = 8'h4F;
      5'b10_011: b = 8'h50;
      5'b10_100: b = 8'h0D;
      5'b10_101: b = 8'h0A;
      5'b11_000: b = 8'h48;
      5'b11_001: b = 8'h49;
      5'b11_010: b = 8'h54;
      5'b11_011: b = 8'h53;
      5'b11_100: b = 8'h5A;
      5'b11_101: b = 8'h0D;
      5'b11_110: b = 8'h0A;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  // Only the three known command results get their own reply; anything
  // else, including the explicit "none" code, is answered with ERR.
  always_comb begin
    case (match_result_i)
      8'h31:   matchCode = 2'd1;
      8'h32:   matchCode = 2'd2;
      8'h33:   matchCode = 2'd3;
      default: matchCode = 2'd0;
    endcase
  end

  assign fifoFull  = (count_q == 3'd4);
  assign fifoEmpty = (count_q == 3'd0);
  assign lastIdx   = replyLen(code_q) - 3'd1;

  // Sequencer. The next byte is loaded into txData on the way into SEND
  // so that it is already valid in the cycle tx_start is high, and it then
  // stays put until the following SEND. A UART that never acknowledges
  // cannot stall the reply: WAIT_ACK gives up after ACK_TIMEOUT cycles.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    txData_d = txData_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        pop      = 1'b1;
        code_d   = fifoMem_q[rdPtr_q];
        idx_d    = 3'd0;
        txData_d = replyByte(fifoMem_q[rdPtr_q], 3'd0);
        state_d  = SEND;
      end
      SEND: begin
        timer_d = 8'd0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TimerLast) begin
          state_d = NEXT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == lastIdx) begin
          state_d = IDLE;
        end else begin
          idx_d    = idx_q + 3'd1;
          txData_d = replyByte(code_q, idx_q + 3'd1);
          state_d  = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping. A pop in the same cycle as a push at full frees the
  // slot first, so the push still goes in. Only a push at full with no pop
  // is lost, and that is what the drop counter records. last_result
  // follows every match, dropped or not, since the display shows what was
  // recognised rather than what will be answered.
  always_comb begin
    push = match_i && (!fifoFull || pop);
    drop = match_i && fifoFull && !pop;

    wrPtr_d = push ? wrPtr_q + 2'd1 : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + 2'd1 : rdPtr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    dropCnt_d = dropCnt_q;
    if (drop && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end

    lastResult_d = match_i ? match_result_i : lastResult_q;
  end

  // FIFO storage needs no reset: the count and pointers decide which
  // entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= matchCode;
    end
  end

  // State registers. Reset drops any reply in progress and empties the
  // FIFO; a byte the UART has already taken is simply left to finish.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      code_q       <= 2'd0;
      idx_q        <= 3'd0;
      timer_q      <= 8'd0;
      txData_q     <= 8'h00;
      wrPtr_q      <= 2'd0;
      rdPtr_q      <= 2'd0;
      count_q      <= 3'd0;
      lastResult_q <= 8'h30;
      dropCnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      txData_q     <= txData_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      lastResult_q <= lastResult_d;
      dropCnt_q    <= dropCnt_d;
    end
  end

  assign tx_start_o    = (state_q == SEND);
  assign tx_data_o     = txData_q;
  assign last_result_o = lastResult_q;
  assign drop_cnt_o    = dropCnt_q;
  assign sched_busy_o  = !fifoEmpty || (state_q != IDLE);

endmodule
